// File: rtl/add_nnbit_digit_serial.sv
// Digit-serial adder/subtractor.
// Computes A+B+cry or A-B-cry over DATA_WIDTH bits, DIGIT_WIDTH bits per clock,
// using one DIGIT_WIDTH-wide ripple slice and a carry flop.
//
// Ports:
//   i_clk, i_rst       clock (rising edge), synchronous active-high reset
//   i_valid, o_ready   operand handshake (o_ready high only when idle)
//   i_num_a, i_num_b   operands
//   i_cry              carry-in (add) / borrow-in (sub)
//   i_sub              0 = add, 1 = subtract
//   o_valid, i_ready   result handshake
//   o_res              result modulo 2^DATA_WIDTH
//   o_cry              carry-out; for subtract 1 = no borrow
//   o_ovf              signed two's-complement overflow
module add_nnbit_digit_serial #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DIGIT_WIDTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_cry,
    input  logic                  i_sub,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_cry,
    output logic                  o_ovf
);

    localparam int N  = int'(DATA_WIDTH / DIGIT_WIDTH);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;  // B already inverted for subtract
    logic                    c_q, c_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic                    cry_q, cry_d;
    logic                    ovf_q, ovf_d;

    logic [DIGIT_WIDTH-1:0]  a_dig, b_dig;
    logic [DIGIT_WIDTH:0]    dig_sum;
    logic                    msb_cin;
    logic                    last_dig;

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(cnt_q) == k) begin
                a_dig = a_q[k*DIGIT_WIDTH +: DIGIT_WIDTH];
                b_dig = b_q[k*DIGIT_WIDTH +: DIGIT_WIDTH];
            end
        end
        dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT_WIDTH{1'b0}}, c_q};
        // Carry into the top bit of the digit, recovered from its sum bit.
        msb_cin  = a_dig[DIGIT_WIDTH-1] ^ b_dig[DIGIT_WIDTH-1] ^ dig_sum[DIGIT_WIDTH-1];
        last_dig = (int'(cnt_q) == N - 1);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cry_d   = cry_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    a_d     = i_num_a;
                    b_d     = i_sub ? ~i_num_b : i_num_b;
                    // A - B - bin = A + ~B + ~bin
                    c_d     = i_cry ^ i_sub;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                for (int k = 0; k < N; k++) begin
                    if (int'(cnt_q) == k) begin
                        res_d[k*DIGIT_WIDTH +: DIGIT_WIDTH] = dig_sum[DIGIT_WIDTH-1:0];
                    end
                end
                c_d   = dig_sum[DIGIT_WIDTH];
                cnt_d = cnt_q + 1'b1;
                if (last_dig) begin
                    state_d = StDone;
                    cry_d   = dig_sum[DIGIT_WIDTH];
                    ovf_d   = msb_cin ^ dig_sum[DIGIT_WIDTH];
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            cry_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cry_q   <= cry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_ready = (state_q == StIdle);
    assign o_valid = (state_q == StDone);
    assign o_res   = res_q;
    assign o_cry   = cry_q;
    assign o_ovf   = ovf_q;

endmodule
